gpr_mp: RTL and testbench



---
 rtl/gpr_pkg.sv | 38 +++
 rtl/gpr_scoreboard.sv | 62 ++++++
 rtl/gpr_mp.sv | 124 ++++++++++++
 tb/tb_gpr_mp.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared definitions for the gpr_mp register file.
// It holds the default geometry, the hard-wired zero register index and the
// write-address one-hot decoder that the scoreboard uses.
package gpr_pkg;

    localparam int GPR_WIDTH_DEFAULT = 32;
    localparam int GPR_DEPTH_DEFAULT = 32;
    localparam int GPR_NREAD_DEFAULT = 2;

    // Number of write ports; the port numbering also sets collision priority
    // (the higher-numbered port wins).
    localparam int GPR_NWRITE = 2;

    // Register that always reads zero and never becomes busy.
    localparam int REG_ZERO = 0;

    // Decoder geometry. Callers zero-extend their AW-bit address to
    // GPR_MAX_AW bits and truncate the result to DEPTH bits, so one decoder
    // serves every parameterisation with DEPTH <= GPR_MAX_DEPTH.
    localparam int GPR_MAX_AW    = 10;
    localparam int GPR_MAX_DEPTH = 1 << GPR_MAX_AW;

    // One-hot decode of an address. The output is all-zero when the enable is
    // low or when the address is the zero register, so callers never need a
    // separate zero-register guard.
    function automatic logic [GPR_MAX_DEPTH-1:0] addr_onehot(
        input logic                  en,
        input logic [GPR_MAX_AW-1:0] addr
    );
        logic [GPR_MAX_DEPTH-1:0] oh;
        oh = '0;
        if (en && (addr != GPR_MAX_AW'(REG_ZERO))) begin
            oh[addr] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits that mark an outstanding producer.
// Issue sets a bit and a writeback clears it; when both land on the same
// register in one cycle, set wins because the new producer supersedes the
// retiring one. busy_cnt is the registered population count of the busy bits.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int DEPTH = GPR_DEPTH_DEFAULT,
    parameter int AW    = $clog2(GPR_DEPTH_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_reg,
    input  logic [GPR_NWRITE-1:0]      we,
    input  logic [GPR_NWRITE*AW-1:0]   waddr,
    output logic [DEPTH-1:0]           busy,
    output logic [AW:0]                busy_cnt
);

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [AW:0]      cnt_reg;
    logic [AW:0]      cnt_next;

    // Decode issue and writeback; clear is applied first so that set wins.
    always_comb begin
        set_vec = DEPTH'(addr_onehot(iss_valid, GPR_MAX_AW'(iss_reg)));
        clr_vec = '0;
        for (int k = 0; k < GPR_NWRITE; k++) begin
            clr_vec = clr_vec | DEPTH'(addr_onehot(we[k], GPR_MAX_AW'(waddr[k*AW +: AW])));
        end
        busy_next = (busy_reg & ~clr_vec) | set_vec;
        busy_next[REG_ZERO] = 1'b0;
    end

    // Population count of the next busy vector; register 0 can never be set,
    // so the result is bounded by DEPTH-1 and fits in AW+1 bits.
    always_comb begin
        cnt_next = '0;
        for (int r = 1; r < DEPTH; r++) begin
            cnt_next = cnt_next + (AW+1)'(busy_next[r]);
        end
    end

    // Busy bits and their count advance together so busy_cnt always matches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = cnt_reg;

endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file for the MIPS-lite core.
// NREAD combinational read ports, two synchronous write ports (port 1 wins a
// same-address collision), register 0 hard-wired to zero, and a scoreboard
// reporting registers with an outstanding producer.
// Optional feature macro: GPR_BYPASS_EN -- when defined, same-cycle write data
// is forwarded to matching read ports and the busy bit about to be cleared by
// that write is hidden from rbusy.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter  int WIDTH = GPR_WIDTH_DEFAULT,
    parameter  int DEPTH = GPR_DEPTH_DEFAULT,
    parameter  int NREAD = GPR_NREAD_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*AW-1:0]       raddr,
    output logic [NREAD*WIDTH-1:0]    rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic [1:0]                we,
    input  logic [2*AW-1:0]           waddr,
    input  logic [2*WIDTH-1:0]        wdata,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_reg,
    output logic [AW:0]               busy_cnt
);

    logic [AW-1:0]                waddr0;
    logic [AW-1:0]                waddr1;
    logic [WIDTH-1:0]             wdata0;
    logic [WIDTH-1:0]             wdata1;
    logic [DEPTH-1:0][WIDTH-1:0]  regs;
    logic [DEPTH-1:0]             busy;

    assign waddr0 = waddr[0  +: AW];
    assign waddr1 = waddr[AW +: AW];
    assign wdata0 = wdata[0     +: WIDTH];
    assign wdata1 = wdata[WIDTH +: WIDTH];

    gpr_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .we        (we),
        .waddr     (waddr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    genvar gi;

    // Storage: one register per address; register 0 is a constant.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == REG_ZERO) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q_reg;

                // Write port 1 is tested first so it wins a collision.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        q_reg <= '0;
                    end else if (we[1] && (waddr1 == AW'(gi))) begin
                        q_reg <= wdata1;
                    end else if (we[0] && (waddr0 == AW'(gi))) begin
                        q_reg <= wdata0;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    // Read ports: a plain mux per port, optionally fronted by write forwarding.
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] rd;
            logic             rb;

            assign ra = raddr[gi*AW +: AW];

`ifdef GPR_BYPASS_EN
            logic hit0;
            logic hit1;
            logic iss_hit;

            assign hit0    = we[0] && (waddr0 == ra) && (ra != AW'(REG_ZERO));
            assign hit1    = we[1] && (waddr1 == ra) && (ra != AW'(REG_ZERO));
            assign iss_hit = iss_valid && (iss_reg == ra);

            // Forward in-flight write data (port 1 over port 0) and hide a
            // busy bit this write retires unless a same-cycle issue re-arms it.
            always_comb begin
                rd = regs[ra];
                if (hit0) begin
                    rd = wdata0;
                end
                if (hit1) begin
                    rd = wdata1;
                end
                rb = busy[ra];
                if ((hit0 || hit1) && !iss_hit) begin
                    rb = 1'b0;
                end
            end
`else
            assign rd = regs[ra];
            assign rb = busy[ra];
`endif

            assign rdata[gi*WIDTH +: WIDTH] = rd;
            assign rbusy[gi]                = rb;
        end
    endgenerate

endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: self-checking bench for gpr_mp (default geometry 32x32, 2 reads).
// Table-driven directed vectors, hand sequences for reset, bypass and fill,
// then randomized traffic checked against a behavioural register/busy model.
module tb_gpr_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NREAD*AW-1:0]    raddr = '0;
    logic [NREAD*WIDTH-1:0] rdata;
    logic [NREAD-1:0]       rbusy;
    logic [1:0]             we = '0;
    logic [2*AW-1:0]        waddr = '0;
    logic [2*WIDTH-1:0]     wdata = '0;
    logic                   iss_valid = 1'b0;
    logic [AW-1:0]          iss_reg = '0;
    logic [AW:0]            busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpr_mp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .busy_cnt  (busy_cnt)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem  [DEPTH];
    logic        m_busy [DEPTH];

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = 32'd0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one clock edge using the inputs currently driven: writes land
    // (port 1 last, so it wins) and retire producers, then issue sets busy.
    task automatic model_edge();
        logic [4:0] a0;
        logic [4:0] a1;
        a0 = waddr[4:0];
        a1 = waddr[9:5];
        if (we[0] && a0 != 5'd0) begin
            m_mem[a0]  = wdata[31:0];
            m_busy[a0] = 1'b0;
        end
        if (we[1] && a1 != 5'd0) begin
            m_mem[a1]  = wdata[63:32];
            m_busy[a1] = 1'b0;
        end
        if (iss_valid && iss_reg != 5'd0) begin
            m_busy[iss_reg] = 1'b1;
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) begin
            if (m_busy[r]) c++;
        end
        return c;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] ra);
        logic [31:0] v;
        v = m_mem[ra];
`ifdef GPR_BYPASS_EN
        if (we[0] && waddr[4:0] == ra && ra != 5'd0) v = wdata[31:0];
        if (we[1] && waddr[9:5] == ra && ra != 5'd0) v = wdata[63:32];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] ra);
        logic b;
        b = m_busy[ra];
`ifdef GPR_BYPASS_EN
        if (((we[0] && waddr[4:0] == ra) || (we[1] && waddr[9:5] == ra)) && ra != 5'd0
            && !(iss_valid && iss_reg == ra)) b = 1'b0;
`endif
        return b;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1);
        we        = w;
        waddr     = {a1, a0};
        wdata     = {d1, d0};
        iss_valid = iv;
        iss_reg   = ir;
        raddr     = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss_v;
        logic [4:0]  iss_r;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] exp_byp_rd;
        logic [1:0]  exp_byp_rb;

        // Each row: inputs applied for one edge, then outputs read with writes idle.
        vecs[0] = '{2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd0,  32'h0,    32'h0,    2'b00, 6'd0};
        vecs[1] = '{2'b11, 5'd7,  32'h11,        5'd7,  32'h22,   1'b0, 5'd0,  5'd7,  5'd7,  32'h22,   32'h22,   2'b00, 6'd0};
        vecs[2] = '{2'b11, 5'd3,  32'hA,         5'd4,  32'hB,    1'b0, 5'd0,  5'd3,  5'd4,  32'hA,    32'hB,    2'b00, 6'd0};
        vecs[3] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    1'b1, 5'd9,  5'd9,  5'd3,  32'h0,    32'hA,    2'b01, 6'd1};
        vecs[4] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    1'b1, 5'd9,  5'd9,  5'd4,  32'h0,    32'hB,    2'b01, 6'd1};
        vecs[5] = '{2'b01, 5'd9,  32'h99,        5'd0,  32'h0,    1'b1, 5'd9,  5'd9,  5'd9,  32'h99,   32'h99,   2'b11, 6'd1};
        vecs[6] = '{2'b10, 5'd0,  32'h0,         5'd9,  32'h55,   1'b0, 5'd0,  5'd9,  5'd7,  32'h55,   32'h22,   2'b00, 6'd0};
        vecs[7] = '{2'b01, 5'd5,  32'h5,         5'd0,  32'h0,    1'b1, 5'd20, 5'd5,  5'd20, 32'h5,    32'h0,    2'b10, 6'd1};
        vecs[8] = '{2'b10, 5'd0,  32'h0,         5'd20, 32'h2020, 1'b1, 5'd21, 5'd20, 5'd21, 32'h2020, 32'h0,    2'b10, 6'd1};
        vecs[9] = '{2'b11, 5'd21, 32'h21,        5'd21, 32'h2121, 1'b0, 5'd0,  5'd21, 5'd0,  32'h2121, 32'h0,    2'b00, 6'd0};

        // ---- reset state ----
        model_reset();
        idle(5'd5, 5'd9);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rdata0", rdata[31:0], 32'd0);
        check("reset_rdata1", rdata[63:32], 32'd0);
        check("reset_rbusy", 32'(rbusy), 32'd0);
        check("reset_busy_cnt", 32'(busy_cnt), 32'd0);
        $display("[%0t] reset: rdata=%h rbusy=%b busy_cnt=%0d", $time, rdata, rbusy, busy_cnt);
        rst = 1'b1;
        #1;

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].iss_v, vecs[i].iss_r, vecs[i].ra0, vecs[i].ra1);
            tick();
            idle(vecs[i].ra0, vecs[i].ra1);
            #1;
            $display("[%0t] vec %0d: we=%b wa=%0d/%0d iss=%b/%0d -> rd=%h/%h rb=%b cnt=%0d",
                     $time, i, vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].iss_v, vecs[i].iss_r,
                     rdata[31:0], rdata[63:32], rbusy, busy_cnt);
            check($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e_rd0);
            check($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e_rd1);
            check($sformatf("vec%0d_rbusy", i), 32'(rbusy), 32'(vecs[i].e_rb));
            check($sformatf("vec%0d_busy_cnt", i), 32'(busy_cnt), 32'(vecs[i].e_cnt));
        end

        // ---- bypass: same-cycle write to a read address ----
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd13, 5'd12, 5'd13);
        tick();
        drive(2'b11, 5'd12, 32'h1234, 5'd13, 32'h1313, 1'b0, 5'd0, 5'd12, 5'd13);
        #1;
`ifdef GPR_BYPASS_EN
        exp_byp_rd = 32'h1234;
        exp_byp_rb = 2'b00;
`else
        exp_byp_rd = 32'h0;
        exp_byp_rb = 2'b10;
`endif
        $display("[%0t] bypass same-cycle: rd0=%h rbusy=%b", $time, rdata[31:0], rbusy);
        check("bypass_same_rdata0", rdata[31:0], exp_byp_rd);
        check("bypass_same_rbusy", 32'(rbusy), 32'(exp_byp_rb));
        tick();
        idle(5'd12, 5'd13);
        #1;
        $display("[%0t] bypass next-cycle: rd=%h/%h rbusy=%b", $time, rdata[31:0], rdata[63:32], rbusy);
        check("bypass_next_rdata0", rdata[31:0], 32'h1234);
        check("bypass_next_rdata1", rdata[63:32], 32'h1313);
        check("bypass_next_rbusy", 32'(rbusy), 32'd0);

        // ---- asynchronous reset between edges, and reset discarding a write ----
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b1, 5'd6, 5'd5, 5'd6);
        tick();
        idle(5'd5, 5'd6);
        #1;
        check("prereset_rdata0", rdata[31:0], 32'hDEAD_BEEF);
        check("prereset_rbusy", 32'(rbusy), 32'h2);
        check("prereset_busy_cnt", 32'(busy_cnt), 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        $display("[%0t] async reset: rd0=%h rbusy=%b cnt=%0d", $time, rdata[31:0], rbusy, busy_cnt);
        check("async_reset_rdata0", rdata[31:0], 32'd0);
        check("async_reset_rbusy", 32'(rbusy), 32'd0);
        check("async_reset_busy_cnt", 32'(busy_cnt), 32'd0);
        drive(2'b01, 5'd5, 32'hCAFE_F00D, 5'd0, 32'd0, 1'b1, 5'd6, 5'd5, 5'd6);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5'd5, 5'd6);
        #1;
        $display("[%0t] write under reset: rd0=%h cnt=%0d", $time, rdata[31:0], busy_cnt);
        check("reset_write_discard", rdata[31:0], 32'd0);
        check("reset_issue_discard", 32'(busy_cnt), 32'd0);

        // ---- fill the scoreboard, then release with both write ports ----
        for (int r = 1; r < DEPTH; r++) begin
            a0 = 5'(r);
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, a0, a0, 5'd0);
            tick();
            $display("[%0t] fill issue r%0d: busy_cnt=%0d", $time, r, busy_cnt);
        end
        idle(5'd1, 5'd31);
        #1;
        check("fill_busy_cnt", 32'(busy_cnt), 32'(DEPTH - 1));
        check("fill_rbusy", 32'(rbusy), 32'h3);
        for (int r = 1; r < DEPTH; r += 2) begin
            a0 = 5'(r);
            if (r + 1 < DEPTH) begin
                a1 = 5'(r + 1);
                drive(2'b11, a0, 32'h100 + 32'(r), a1, 32'h100 + 32'(r + 1), 1'b0, 5'd0, 5'd1, 5'd31);
            end else begin
                drive(2'b01, a0, 32'h100 + 32'(r), 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31);
            end
            tick();
            $display("[%0t] release r%0d..: busy_cnt=%0d", $time, r, busy_cnt);
        end
        idle(5'd1, 5'd31);
        #1;
        check("release_busy_cnt", 32'(busy_cnt), 32'd0);
        check("release_rbusy", 32'(rbusy), 32'd0);
        check("release_rdata0", rdata[31:0], 32'h101);
        check("release_rdata1", rdata[63:32], 32'h11F);

        // ---- randomized traffic against the reference model ----
        for (int t = 0; t < 400; t++) begin
            logic [1:0] w;
            logic       iv;
            logic [4:0] ir;
            w  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                a0 = 5'($urandom_range(0, 7));
                a1 = 5'($urandom_range(0, 7));
                ir = 5'($urandom_range(0, 7));
                ra0 = 5'($urandom_range(0, 7));
                ra1 = 5'($urandom_range(0, 7));
            end else begin
                a0 = 5'($urandom_range(0, 31));
                a1 = 5'($urandom_range(0, 31));
                ir = 5'($urandom_range(0, 31));
                ra0 = 5'($urandom_range(0, 31));
                ra1 = 5'($urandom_range(0, 31));
            end
            iv = 1'($urandom_range(0, 1));
            drive(w, a0, $urandom, a1, $urandom, iv, ir, ra0, ra1);
            #1;
            $display("[%0t] rand %0d: we=%b wa=%0d/%0d iss=%b/%0d ra=%0d/%0d rd=%h/%h rb=%b cnt=%0d",
                     $time, t, w, a0, a1, iv, ir, ra0, ra1, rdata[31:0], rdata[63:32], rbusy, busy_cnt);
            check("rand_rdata0", rdata[31:0], exp_rdata(ra0));
            check("rand_rdata1", rdata[63:32], exp_rdata(ra1));
            check("rand_rbusy0", 32'(rbusy[0]), 32'(exp_rbusy(ra0)));
            check("rand_rbusy1", 32'(rbusy[1]), 32'(exp_rbusy(ra1)));
            check("rand_busy_cnt", 32'(busy_cnt), 32'(m_cnt()));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
